// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop sync, per-button debounce, press pulses and a packed status word.
// Define BUTTON_AUTOREPEAT_EN to build per-button hold counters that re-pulse btn_press while held.
module button_conditioner #(
    parameter int unsigned NUM_BUTTONS     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [31:0]            button_export
);

    localparam int unsigned            CntW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0]        CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_BUTTONS-1:0] RawIdle = {NUM_BUTTONS{ACTIVE_LOW}};

    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] synced;
    logic [NUM_BUTTONS-1:0] stable_q, stable_d;
    logic [NUM_BUTTONS-1:0] stable_prev_q;
    logic [CntW-1:0]        cnt_q [NUM_BUTTONS];
    logic [CntW-1:0]        cnt_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] edge_press;
    logic [NUM_BUTTONS-1:0] rep_fire;
    logic [7:0]             press_count_q, press_count_d;
    logic [7:0]             press_pop;
    logic [3:0]             last_idx_q, last_idx_d;
    logic                   seen_q, seen_d;
    logic [15:0]            level_ext;
    logic [31:0]            export_q, export_d;

    // Synchronizer idles at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RawIdle;
            sync2_q <= RawIdle;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign synced = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_d[i] = '0;
            if (synced[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign edge_press = stable_q & ~stable_prev_q;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HoldW  = $clog2(RepMax + 1);

    logic [HoldW-1:0]       hold_q [NUM_BUTTONS];
    logic [HoldW-1:0]       hold_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] repeating_q, repeating_d;

    // hold counts cycles since the press edge (or the last repeat); it restarts at 1 after a
    // repeat so the firing cycle is the first cycle of the next period.
    always_comb begin
        rep_fire    = '0;
        repeating_d = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            hold_d[i] = '0;
            if (stable_q[i]) begin
                rep_fire[i] = (hold_q[i] == (repeating_q[i] ? HoldW'(REPEAT_PERIOD)
                                                            : HoldW'(REPEAT_DELAY)));
                if (rep_fire[i]) begin
                    hold_d[i]      = HoldW'(1);
                    repeating_d[i] = 1'b1;
                end else begin
                    hold_d[i]      = hold_q[i] + HoldW'(1);
                    repeating_d[i] = repeating_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            repeating_q <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            repeating_q <= repeating_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end
`else
    // Repeat timing is inert without auto-repeat; the mask folds to zero.
    assign rep_fire = {NUM_BUTTONS{(REPEAT_DELAY == 0) && (REPEAT_PERIOD == 0)}} & '0;
`endif

    assign btn_press = edge_press | rep_fire;

    always_comb begin
        press_pop = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            press_pop = press_pop + 8'(btn_press[i]);
        end
        press_count_d = press_count_q + press_pop;

        last_idx_d = last_idx_q;
        seen_d     = seen_q;
        if (|btn_press) begin
            seen_d = 1'b1;
            for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
                if (btn_press[i]) begin
                    last_idx_d = 4'(i);
                end
            end
        end

        level_ext                  = '0;
        level_ext[NUM_BUTTONS-1:0] = stable_q;
        // Counter fields use next-state values so every field lags its event by one cycle.
        export_d = {3'b000, seen_d, last_idx_d, press_count_d, level_ext};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_count_q <= '0;
            last_idx_q    <= '0;
            seen_q        <= 1'b0;
            export_q      <= '0;
        end else begin
            press_count_q <= press_count_d;
            last_idx_q    <= last_idx_d;
            seen_q        <= seen_d;
            export_q      <= export_d;
        end
    end

    assign btn_level     = stable_q;
    assign button_export = export_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random pressing, checked every cycle
// against a sliding-window behavioural model.
module tb_button_conditioner;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_raw = '1;
    logic [NB-1:0] btn_level, btn_press;
    logic [31:0]   button_export;

    int n_tests = 0;
    int n_fail  = 0;

    button_conditioner #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DB),
        .ACTIVE_LOW     (1'b1),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .button_export(button_export)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a level flips once the last DB synchronized samples all disagree with it.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_level, m_press;
    logic [7:0]    m_count;
    logic [3:0]    m_last;
    logic          m_seen;
    logic [31:0]   m_export;
    int            m_age[NB];

    task automatic model_reset();
        hist = {};
        for (int k = 0; k < DB + 2; k++) hist.push_back('0);
        m_level  = '0;
        m_press  = '0;
        m_count  = '0;
        m_last   = '0;
        m_seen   = 1'b0;
        m_export = '0;
        for (int i = 0; i < NB; i++) m_age[i] = -1;
    endtask

    task automatic model_step();
        logic [NB-1:0] prev, h;
        bit            all_diff, found;
        m_count = m_count + 8'($countones(m_press));
        found = 0;
        for (int i = 0; i < NB; i++) begin
            if (m_press[i] && !found) begin
                m_last = 4'(i);
                m_seen = 1'b1;
                found  = 1;
            end
        end
        m_export = {3'b000, m_seen, m_last, m_count, 16'(m_level)};

        hist.push_back(~btn_raw);
        if (hist.size() > DB + 2) void'(hist.pop_front());
        prev = m_level;
        for (int i = 0; i < NB; i++) begin
            all_diff = 1;
            for (int k = 0; k < DB; k++) begin
                h = hist[k];
                if (h[i] == m_level[i]) all_diff = 0;
            end
            if (all_diff) m_level[i] = ~m_level[i];
        end

        for (int i = 0; i < NB; i++) begin
            if (m_level[i]) m_age[i] = prev[i] ? m_age[i] + 1 : 0;
            else m_age[i] = -1;
            m_press[i] = m_level[i] && (m_age[i] == 0);
`ifdef BUTTON_AUTOREPEAT_EN
            if (m_level[i] && m_age[i] >= RD && ((m_age[i] - RD) % RP) == 0) m_press[i] = 1'b1;
`endif
        end
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else model_step();
    end

    int            pulse_cnt[NB];
    logic [NB-1:0] lvl_seen;

    always @(posedge clk) begin
        #2;
        check("level", 32'(btn_level), 32'(m_level));
        check("press", 32'(btn_press), 32'(m_press));
        check("export", button_export, m_export);
        if (!reset) begin
            for (int i = 0; i < NB; i++) pulse_cnt[i] += int'(btn_press[i]);
            lvl_seen |= btn_level;
        end
    end

    task automatic clear_pulses();
        for (int i = 0; i < NB; i++) pulse_cnt[i] = 0;
    endtask

    task automatic wait_level(input int idx, output int cyc);
        cyc = 0;
        while (!btn_level[idx] && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int tmr[NB];
        lvl_seen = '0;
        clear_pulses();
        repeat (3) @(negedge clk);
        check("reset_export", button_export, 32'h0);
        check("reset_level", 32'(btn_level), 32'h0);
        reset = 1'b0;

        // Idle: nothing pressed for 100 cycles.
        repeat (100) @(negedge clk);
        check("idle_pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 0);
        check("idle_export", button_export, 32'h0);

        // Single press of button 1.
        clear_pulses();
        btn_raw[1] = 1'b0;
        wait_level(1, cyc);
        check("p1_latency_in_6pm1", 32'(cyc >= 5 && cyc <= 7), 32'd1);
        repeat (3) @(negedge clk);
        check("p1_export", button_export, 32'h1101_0002);
        check("p1_pulses", 32'(pulse_cnt[1]), 32'd1);
        btn_raw[1] = 1'b1;
        repeat (10) @(negedge clk);

        // Bounce on button 0: toggles every 2 cycles, never accepted.
        lvl_seen = '0;
        for (int k = 0; k < 10; k++) begin
            btn_raw[0] = ~btn_raw[0];
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("bounce_no_level", 32'(lvl_seen[0]), 32'd0);
        check("bounce_count", 32'(button_export[23:16]), 32'd1);

        // Simultaneous press of buttons 0 and 2.
        btn_raw = 4'b1010;
        cyc = 0;
        while (btn_press == '0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("dual_press_bits", 32'(btn_press), 32'h5);
        repeat (2) @(negedge clk);
        check("dual_count", 32'(button_export[23:16]), 32'd3);
        check("dual_last", 32'(button_export[27:24]), 32'd0);
        check("dual_levels", 32'(button_export[15:0]), 32'h5);
        btn_raw = 4'b1111;
        repeat (10) @(negedge clk);

        // 256 presses of button 3 wrap the counter back to 3.
        clear_pulses();
        for (int k = 0; k < 256; k++) begin
            btn_raw[3] = 1'b0;
            repeat (8) @(negedge clk);
            btn_raw[3] = 1'b1;
            repeat (8) @(negedge clk);
        end
        check("wrap_count", 32'(button_export[23:16]), 32'd3);
        check("wrap_last", 32'(button_export[27:24]), 32'd3);
        check("wrap_seen", 32'(button_export[28]), 32'd1);
        check("wrap_pulses", 32'(pulse_cnt[3]), 32'd256);

        // Reset mid-debounce on button 2, still held afterwards.
        btn_raw = 4'b1011;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_export", button_export, 32'h0);
        check("midrst_level", 32'(btn_level), 32'h0);
        check("midrst_press", 32'(btn_press), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        clear_pulses();
        wait_level(2, cyc);
        check("midrst_latency_in_6pm1", 32'(cyc >= 5 && cyc <= 7), 32'd1);
        repeat (2) @(negedge clk);
        check("midrst_export_after", button_export, 32'h1201_0004);
        // Keep holding: hold cycles 0..59 after acceptance.
        repeat (57) @(negedge clk);
`ifdef BUTTON_AUTOREPEAT_EN
        check("hold_pulses", 32'(pulse_cnt[2]), 32'd6);
        check("hold_count", 32'(button_export[23:16]), 32'd6);
`else
        check("hold_pulses", 32'(pulse_cnt[2]), 32'd1);
        check("hold_count", 32'(button_export[23:16]), 32'd1);
`endif
        btn_raw = 4'b1111;
        repeat (10) @(negedge clk);

        // Random pressing, bouncing and occasional resets, checked by the model.
        for (int i = 0; i < NB; i++) tmr[i] = $urandom_range(0, 10);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                if (tmr[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    tmr[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                         : $urandom_range(4, 45);
                end else begin
                    tmr[i]--;
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        btn_raw = 4'b1111;
        repeat (20) @(negedge clk);
        check("final_levels_released", 32'(btn_level), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
